// File: rtl/hilo_issue_ctrl.sv
// hilo_issue_ctrl
//   Issue-side controller for the multi-cycle multiply/divide unit. It accepts
//   multiply, divide, multiply-accumulate and MTHI/MTLO operations, latches
//   their operands, and holds them on the unit's inputs while the unit is busy.
//   It then commits the 64-bit result into the architectural HI/LO pair it owns,
//   and stalls the pipeline for the whole occupancy. A watchdog aborts an
//   operation that overstays TIMEOUT cycles in WAIT.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush                 pipeline flush, aborts any in-flight operation
//   in_valid/in_op        operation presented by the pipeline
//   in_reg1/in_reg2       source operands
//   stall                 hold the pipeline (combinational)
//   result_valid          one-cycle pulse, MUL GPR result on result_word
//   result_word           low word of the MUL product
//   hilo                  architectural {HI, LO}
//   timeout               one-cycle pulse, watchdog abort
//   mc_flush              flush forwarded to the execution unit
//   mc_op/mc_reg1/mc_reg2 registered operation and operands to the unit
//   mc_hilo               accumulate base for MADD/MSUB
//   mc_ret/mc_mult_word   unit results, valid when mc_busy is low
//   mc_busy               unit busy

package hilo_issue_pkg;
  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_MULT  = 5'd1,
    OP_MULTU = 5'd2,
    OP_MUL   = 5'd3,
    OP_MADD  = 5'd4,
    OP_MADDU = 5'd5,
    OP_MSUB  = 5'd6,
    OP_MSUBU = 5'd7,
    OP_DIV   = 5'd8,
    OP_DIVU  = 5'd9,
    OP_MTHI  = 5'd10,
    OP_MTLO  = 5'd11,
    OP_ADD   = 5'd12,
    OP_SUB   = 5'd13,
    OP_AND   = 5'd14
  } oper_t;
endpackage

module hilo_issue_ctrl
  import hilo_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  oper_t       in_op,
  input  logic [31:0] in_reg1,
  input  logic [31:0] in_reg2,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result_word,
  output logic [63:0] hilo,
  output logic        timeout,
  output logic        mc_flush,
  output oper_t       mc_op,
  output logic [31:0] mc_reg1,
  output logic [31:0] mc_reg2,
  output logic [63:0] mc_hilo,
  input  logic [63:0] mc_ret,
  input  logic [31:0] mc_mult_word,
  input  logic        mc_busy
);

  // Counter holds up to TIMEOUT: it bumps once more on the cycle WAIT exits.
  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  oper_t         mc_op_q;
  logic [31:0]   mc_reg1_q, mc_reg2_q;
  logic [31:0]   hi_q, lo_q;
  logic [CW-1:0] cnt_q;

  logic accept, wr_hi, wr_lo, complete, wd_fire;

  function automatic logic is_multicycle(input oper_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Event decode; flush masks every event so it wins over accept,
  // MTHI/MTLO writes, completion and the watchdog alike.
  always_comb begin
    accept   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    complete = 1'b0;
    wd_fire  = 1'b0;
    if (!flush) begin
      if (state_q == S_IDLE) begin
        if (in_valid) begin
          accept = is_multicycle(in_op);
          wr_hi  = (in_op == OP_MTHI);
          wr_lo  = (in_op == OP_MTLO);
        end
      end else begin
        complete = !mc_busy;
        wd_fire  = mc_busy && (cnt_q == CNT_LAST);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: if (flush || complete || wd_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    stall        = accept || ((state_q == S_WAIT) && mc_busy && !flush);
    result_valid = complete && (mc_op_q == OP_MUL);
    result_word  = mc_mult_word;
    timeout      = wd_fire;
    mc_flush     = flush || wd_fire;
  end

  // Operand latch, watchdog counter and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_op_q   <= OP_NOP;
      mc_reg1_q <= '0;
      mc_reg2_q <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        mc_op_q   <= in_op;
        mc_reg1_q <= in_reg1;
        mc_reg2_q <= in_reg2;
        cnt_q     <= '0;
      end else if (state_q == S_WAIT) begin
        if (flush || complete || wd_fire) mc_op_q <= OP_NOP;
        cnt_q <= cnt_q + CW'(1);
      end

      // Completion only happens in WAIT and MT writes only in IDLE,
      // so the two HI/LO write sources never collide.
      if (complete && (mc_op_q != OP_MUL)) begin
        hi_q <= mc_ret[63:32];
        lo_q <= mc_ret[31:0];
      end else begin
        if (wr_hi) hi_q <= in_reg1;
        if (wr_lo) lo_q <= in_reg1;
      end
    end
  end

  assign hilo    = {hi_q, lo_q};
  assign mc_hilo = {hi_q, lo_q};
  assign mc_op   = mc_op_q;
  assign mc_reg1 = mc_reg1_q;
  assign mc_reg2 = mc_reg2_q;

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
module tb_hilo_issue_ctrl;
  import hilo_issue_pkg::*;

  logic        clk, rst, flush, in_valid;
  oper_t       in_op;
  logic [31:0] in_reg1, in_reg2;
  logic        stall, result_valid, timeout, mc_flush, mc_busy;
  logic [31:0] result_word, mc_reg1, mc_reg2, mc_mult_word;
  logic [63:0] hilo, mc_hilo, mc_ret;
  oper_t       mc_op;

  hilo_issue_ctrl #(.TIMEOUT(48)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .stall(stall),
    .result_valid(result_valid), .result_word(result_word), .hilo(hilo),
    .timeout(timeout), .mc_flush(mc_flush), .mc_op(mc_op), .mc_reg1(mc_reg1),
    .mc_reg2(mc_reg2), .mc_hilo(mc_hilo), .mc_ret(mc_ret),
    .mc_mult_word(mc_mult_word), .mc_busy(mc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Execution-unit stand-in: busy from the first cycle mc_op is non-NOP,
  // for 1 cycle (multiply class) or 35 cycles (divide). Results are garbage
  // while busy so an early commit is visible.
  logic hang = 1'b0;
  int   age;
  always @(posedge clk) age <= (mc_op != OP_NOP) ? age + 1 : 0;

  function automatic int unit_lat(input oper_t op);
    return (op == OP_DIV || op == OP_DIVU) ? 35 : 1;
  endfunction

  assign mc_busy = hang || ((mc_op != OP_NOP) && (age < unit_lat(mc_op)));

  logic signed [63:0] u_sp;
  logic [63:0]        u_up, u_val;
  always_comb begin
    u_sp  = $signed({{32{mc_reg1[31]}}, mc_reg1}) * $signed({{32{mc_reg2[31]}}, mc_reg2});
    u_up  = {32'd0, mc_reg1} * {32'd0, mc_reg2};
    u_val = 64'hFFFF_FFFF_FFFF_FFFF;
    case (mc_op)
      OP_MULT, OP_MUL: u_val = u_sp;
      OP_MULTU:        u_val = u_up;
      OP_MADD:         u_val = mc_hilo + u_sp;
      OP_MADDU:        u_val = mc_hilo + u_up;
      OP_MSUB:         u_val = mc_hilo - u_sp;
      OP_MSUBU:        u_val = mc_hilo - u_up;
      OP_DIV:  if (mc_reg2 != 0)
                 u_val = {32'($signed(mc_reg1) % $signed(mc_reg2)),
                          32'($signed(mc_reg1) / $signed(mc_reg2))};
      OP_DIVU: if (mc_reg2 != 0) u_val = {mc_reg1 % mc_reg2, mc_reg1 / mc_reg2};
      default: u_val = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mc_ret       = mc_busy ? 64'hBADB_AD00_BADB_AD00 : u_val;
    mc_mult_word = mc_busy ? 32'hBADB_AD00 : u_val[31:0];
  end

  // Reference model: architectural HI/LO after each operation.
  logic [63:0] m_hilo = '0;

  function automatic logic [63:0] ref_hilo(input oper_t op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    sp = longint'(int'(a)) * longint'(int'(b));
    up = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return acc + sp;
      OP_MADDU: return acc + up;
      OP_MSUB:  return acc - sp;
      OP_MSUBU: return acc - up;
      OP_DIV: begin
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {32'(r), 32'(q)};
      end
      OP_DIVU:  return {a % b, a / b};
      default:  return acc;
    endcase
  endfunction

  localparam int K_HILO = 0, K_RV = 1, K_TO = 2;
  typedef struct { int kind; logic [63:0] val; } exp_t;
  exp_t sbq[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [63:0] act, input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected DUT event, got 0x%h, expected none", nm, act);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_kind"}, 64'(kind), 64'(e.kind));
      chk(nm, act, e.val);
    end
  endtask

  // Monitor: result/timeout pulses, and HI/LO one cycle after stall falls.
  initial begin : monitor
    bit prev_stall, pend;
    prev_stall = 1'b0;
    pend       = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (pend) begin
        pop_chk(K_HILO, hilo, "hilo_commit");
        pend = 1'b0;
      end
      if (result_valid === 1'b1) pop_chk(K_RV, {32'd0, result_word}, "mul_word");
      if (timeout === 1'b1) pop_chk(K_TO, hilo, "timeout_hilo");
      if (prev_stall && stall !== 1'b1) pend = 1'b1;
      prev_stall = (stall === 1'b1);
    end
  end

  task automatic issue(input oper_t op, input logic [31:0] a, input logic [31:0] b,
                       output int t0, output int t_done);
    int st, k;
    if (op == OP_MUL) push(K_RV, {32'd0, a * b});
    m_hilo = ref_hilo(op, a, b, m_hilo);
    push(K_HILO, m_hilo);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_reg1 = a; in_reg2 = b;
    t0 = cyc;
    #1;
    chk("c0_mc_op", 64'(mc_op), 64'(OP_NOP));
    st = (stall === 1'b1) ? 1 : 0;
    @(negedge clk);
    in_valid = 1'b0; in_op = OP_NOP;
    #1;
    chk("c1_mc_op", 64'(mc_op), 64'(op));
    k = 1;
    while (stall === 1'b1 && k < 200) begin
      st++;
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 200) chk("completion_bound", 64'(k), 64'(0));
    t_done = cyc;
    chk("stall_cycles", 64'(st), (op == OP_DIV || op == OP_DIVU) ? 64'd36 : 64'd2);
  endtask

  task automatic mt(input oper_t op, input logic [31:0] v);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_reg1 = v; in_reg2 = $urandom;
    #1;
    chk("mt_no_stall", 64'(stall), 64'd0);
    if (op == OP_MTHI) m_hilo[63:32] = v;
    else               m_hilo[31:0]  = v;
    @(negedge clk);
    in_valid = 1'b0; in_op = OP_NOP;
    #1;
    chk("mt_hilo", hilo, m_hilo);
  endtask

  task automatic ignored(input oper_t op);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_reg1 = $urandom; in_reg2 = $urandom;
    #1;
    chk("ignored_no_stall", 64'(stall), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; in_op = OP_NOP;
    #1;
    chk("ignored_hilo", hilo, m_hilo);
    chk("ignored_mc_op", 64'(mc_op), 64'(OP_NOP));
  endtask

  oper_t rnd_ops[13] = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB,
                         OP_MSUBU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_ADD, OP_AND};

  initial begin : driver
    int t0a, tda, t0b, tdb, k;
    logic [31:0] a, b;
    oper_t op;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = OP_NOP;
    in_reg1 = '0; in_reg2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hilo", hilo, 64'd0);
    chk("rst_mc_op", 64'(mc_op), 64'(OP_NOP));
    chk("rst_mc_regs", {mc_reg1, mc_reg2}, 64'd0);
    chk("rst_flags", {60'd0, stall, result_valid, timeout, mc_flush}, 64'd0);

    // MULT -2 x 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, t0a, tda);
    @(negedge clk); #1;
    chk("mult_hilo_c3", hilo, 64'hFFFF_FFFF_FFFF_FFFA);

    // DIV -7 / 2, then DIVU back-to-back
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, t0a, tda);
    chk("div_done_c36", 64'(tda - t0a), 64'd36);
    issue(OP_DIVU, 32'd100, 32'd7, t0b, tdb);
    chk("divu_accept_c37", 64'(t0b - t0a), 64'd37);
    chk("divu_done_c73", 64'(tdb - t0a), 64'd73);

    // MADD over MT-loaded base
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'd5);
    issue(OP_MADD, 32'd3, 32'd4, t0a, tda);
    @(negedge clk); #1;
    chk("madd_hilo", hilo, 64'h0000_0000_0000_0011);

    // MUL 7 x 6
    issue(OP_MUL, 32'd7, 32'd6, t0a, tda);

    // Flush at c10 of a DIV; in_valid during WAIT and during the flush is ignored
    push(K_HILO, m_hilo);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIV; in_reg1 = 32'd1000; in_reg2 = 32'd3;
    @(negedge clk);
    in_op = OP_MTLO; in_reg1 = 32'h0000_1234;
    repeat (9) @(negedge clk);
    flush = 1'b1; in_op = OP_MTHI; in_reg1 = 32'hDEAD_BEEF;
    #1;
    chk("flush_mc_flush", 64'(mc_flush), 64'd1);
    chk("flush_stall", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; in_op = OP_NOP;
    #1;
    chk("flush_c11_stall", 64'(stall), 64'd0);
    chk("flush_c11_mc_op", 64'(mc_op), 64'(OP_NOP));
    chk("flush_c11_hilo", hilo, m_hilo);

    // Watchdog: unit never drops busy
    push(K_TO, m_hilo);
    push(K_HILO, m_hilo);
    hang = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIV; in_reg1 = 32'd50; in_reg2 = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; in_op = OP_NOP;
    k = 1;
    #1;
    while (timeout !== 1'b1 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("timeout_cycle", 64'(k), 64'd48);
    chk("timeout_mc_flush", 64'(mc_flush), 64'd1);
    @(negedge clk);
    hang = 1'b0;
    #1;
    chk("timeout_next_mc_op", 64'(mc_op), 64'(OP_NOP));
    repeat (2) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = rnd_ops[$urandom_range(0, 12)];
      a  = $urandom;
      b  = $urandom;
      if (op == OP_DIV || op == OP_DIVU) begin
        if ($urandom_range(0, 1) == 0) b = b % 32'd1000;
        if (b == 0) b = 32'd3;
        if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      end
      case (op)
        OP_MTHI, OP_MTLO: mt(op, a);
        OP_ADD, OP_AND:   ignored(op);
        default:          issue(op, a, b, t0a, tda);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a DIV
    push(K_HILO, 64'd0);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIV; in_reg1 = 32'd77; in_reg2 = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; in_op = OP_NOP;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hilo = '0;
    #1;
    chk("midrst_hilo", hilo, 64'd0);
    chk("midrst_mc_op", 64'(mc_op), 64'(OP_NOP));
    chk("midrst_mc_regs", {mc_reg1, mc_reg2}, 64'd0);
    chk("midrst_flags", {60'd0, stall, result_valid, timeout, mc_flush}, 64'd0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0a, tda);

    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
